// File: rtl/board_refresh.sv
// board_refresh: 10x20 playfield storage with piece lock and row-clear engine.
// Row 0 is the top of the board, column 0 is the left edge; bit i of a row
// word is column i.
//
// Handshake with the piece controller:
//   refresh      is a one-cycle request, sampled only while the FSM is IDLE.
//                x/y/mask are captured on the same edge. Requests seen in
//                any other state are dropped, never queued.
//   refresh_done is a one-cycle acknowledge, high during the DONE state.
//                The board, lines and (one cycle later) overflow are final
//                by then. busy is high from LOCK through DONE inclusive.
module board_refresh (
    input  logic        clk,
    input  logic        rstn,
    input  logic        refresh,
    input  logic [4:0]  x,
    input  logic [4:0]  y,
    input  logic [15:0] mask,
    input  logic [4:0]  rd_row,
    output logic [9:0]  rd_data,
    output logic        refresh_done,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] lines,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOCK  = 3'd1,
        SCAN  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [9:0] FULL_ROW = 10'h3FF;
    localparam logic [4:0] LAST_ROW = 5'd19;

    state_t      state;
    state_t      state_nx;

    logic [9:0]  board [0:19];
    logic [4:0]  r;
    logic [4:0]  lx;
    logic [4:0]  ly;
    logic [15:0] lmask;

    // Cells contributed by the latched piece, already clipped to the board.
    logic [9:0]  lock_bits [0:19];
    logic [5:0]  row6;
    logic [5:0]  col6;

    logic        row_full;

    // r never leaves 0..19, so the board index is always in range.
    assign row_full = (board[r] == FULL_ROW);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: one lock cycle, bottom-up scan, shift on a full row.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (refresh) begin
                    state_nx = LOCK;
                end
            end
            LOCK: begin
                state_nx = SCAN;
            end
            SCAN: begin
                if (row_full) begin
                    state_nx = SHIFT;
                end else if (r == 5'd0) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SCAN;
                end
            end
            SHIFT: begin
                // Recheck the same row: it now holds the row from above.
                state_nx = SCAN;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        refresh_done = (state == DONE);
        busy         = (state != IDLE);
        dbg_state    = state;
    end

    // Capture the piece when a request is accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lx    <= 5'd0;
            ly    <= 5'd0;
            lmask <= 16'd0;
        end else if ((state == IDLE) && refresh) begin
            lx    <= x;
            ly    <= y;
            lmask <= mask;
        end
    end

    // Expand the 4x4 mask onto the board; sums are 6 bits so large x/y
    // cannot wrap back onto the board, and off-board cells are dropped.
    always_comb begin
        row6 = 6'd0;
        col6 = 6'd0;
        for (int i = 0; i < 20; i++) begin
            lock_bits[i] = 10'd0;
        end
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                row6 = {1'b0, ly} + 6'(rr);
                col6 = {1'b0, lx} + 6'(cc);
                if (lmask[4*rr+cc] && (col6 < 6'd10) && (row6 < 6'd20)) begin
                    lock_bits[row6[4:0]][col6[3:0]] = 1'b1;
                end
            end
        end
    end

    // Scan pointer: starts at the bottom row after a lock, walks upward,
    // and holds still across a shift so the new row at r is rechecked.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r <= 5'd0;
        end else begin
            case (state)
                LOCK: begin
                    r <= LAST_ROW;
                end
                SCAN: begin
                    if (!row_full && (r != 5'd0)) begin
                        r <= r - 5'd1;
                    end
                end
                default: begin
                    r <= r;
                end
            endcase
        end
    end

    // Board storage: OR in the piece on LOCK, drop rows 0..r down on SHIFT.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 20; i++) begin
                board[i] <= 10'd0;
            end
        end else begin
            case (state)
                LOCK: begin
                    for (int i = 0; i < 20; i++) begin
                        board[i] <= board[i] | lock_bits[i];
                    end
                end
                SHIFT: begin
                    for (int i = 1; i < 20; i++) begin
                        if (5'(i) <= r) begin
                            board[i] <= board[i-1];
                        end
                    end
                    board[0] <= 10'd0;
                end
                default: begin
                    for (int i = 0; i < 20; i++) begin
                        board[i] <= board[i];
                    end
                end
            endcase
        end
    end

    // Cleared-row counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lines <= 16'd0;
        end else if (state == SHIFT) begin
            lines <= lines + 16'd1;
        end
    end

    // Overflow tracks the top row, one cycle behind the board.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else begin
            overflow <= |board[0];
        end
    end

    // Display read port, one cycle latency, zero for rows past the bottom.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data <= 10'd0;
        end else if (rd_row < 5'd20) begin
            rd_data <= board[rd_row];
        end else begin
            rd_data <= 10'd0;
        end
    end

endmodule
